// File: rtl/i2s_tx.sv
// i2s_tx: I2S slave transmitter with a one-deep sample holding register.
// Synchronises the master's BCK/LRCK into the clk domain and shifts the
// sample out MSB first on detected BCK falling edges with the standard I2S
// one-bit delay after each LRCK transition.
//
// Optional feature (macro I2S_TX_STEREO_DUP_EN):
//   defined   - right slot retransmits the current left-slot word
//   undefined - right slot transmits all zeros
//
// Ports:
//   clk          system clock (>= 8x BCK)
//   reset        asynchronous active-low reset
//   bck_i        I2S bit clock from the master (async)
//   lrck_i       I2S word select from the master (0 = left, 1 = right, async)
//   sample_data  sample to transmit (two's complement)
//   sample_valid sample_data is valid
//   sample_ready holding register empty, sample will be accepted
//   sd_out       I2S serial data, MSB first
//   frame_start  one-clk pulse at each left-slot start
//   underrun     one-clk pulse at a left-slot start with no sample held
module i2s_tx #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SLOT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bck_i,
  input  logic              lrck_i,
  input  logic [DATA_W-1:0] sample_data,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              sd_out,
  output logic              frame_start,
  output logic              underrun
);

  localparam int unsigned CNT_W = (SLOT_W > 1) ? $clog2(SLOT_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_W - 1);

  // Synchronisers and edge-detect stage
  logic              r_bck_s1, r_bck_s2, r_bck_d;
  logic              r_lr_s1, r_lr_s2, r_lr_rec;

  // Datapath state
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_tx_word;
  logic [DATA_W-1:0] r_hold;
  logic              r_hold_full;
  logic              r_ready;
  logic              r_sd;
  logic              r_frame_start;
  logic              r_underrun;

  // Next-state values
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [DATA_W-1:0] w_tx_nxt;
  logic [DATA_W-1:0] w_hold_nxt;
  logic              w_full_nxt;
  logic              w_sd_nxt;
  logic              w_fs_nxt;
  logic              w_ur_nxt;

  logic w_fall, w_slot_start, w_left_start, w_right_start, w_accept;

  assign w_fall        = r_bck_d & ~r_bck_s2;
  // LRCK is compared against the value recorded at the previous fall, so a
  // slot start is only ever seen on a BCK fall.
  assign w_slot_start  = w_fall & (r_lr_s2 != r_lr_rec);
  assign w_left_start  = w_slot_start & ~r_lr_s2;
  assign w_right_start = w_slot_start &  r_lr_s2;
  assign w_accept      = sample_valid & ~r_hold_full;

  assign sample_ready = r_ready;
  assign sd_out       = r_sd;
  assign frame_start  = r_frame_start;
  assign underrun     = r_underrun;

  // Next-state logic for slot sequencing, shifting and the holding register
  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_tx_nxt    = r_tx_word;
    w_hold_nxt  = r_hold;
    w_full_nxt  = r_hold_full;
    w_sd_nxt    = r_sd;
    w_fs_nxt    = 1'b0;
    w_ur_nxt    = 1'b0;

    // Accept only when empty; a sample taken in the same clk as a left start
    // lands in the holder and waits for the next frame.
    if (w_accept) begin
      w_hold_nxt = sample_data;
      w_full_nxt = 1'b1;
    end

    if (w_left_start) begin
      w_fs_nxt  = 1'b1;
      w_cnt_nxt = '0;
      w_sd_nxt  = 1'b0;
      if (r_hold_full) begin
        w_tx_nxt    = r_hold;
        w_shift_nxt = r_hold;
        w_full_nxt  = 1'b0;
      end else begin
        w_tx_nxt    = '0;
        w_shift_nxt = '0;
        w_ur_nxt    = 1'b1;
      end
    end else if (w_right_start) begin
      w_cnt_nxt = '0;
      w_sd_nxt  = 1'b0;
`ifdef I2S_TX_STEREO_DUP_EN
      w_shift_nxt = r_tx_word;
`else
      w_shift_nxt = '0;
`endif
    end else if (w_fall) begin
      if (32'(r_cnt) < DATA_W) begin
        w_sd_nxt    = r_shift[DATA_W-1];
        w_shift_nxt = r_shift << 1;
      end else begin
        w_sd_nxt = 1'b0;
      end
      if (r_cnt != CNT_MAX) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bck_s1      <= 1'b0;
      r_bck_s2      <= 1'b0;
      r_bck_d       <= 1'b0;
      r_lr_s1       <= 1'b0;
      r_lr_s2       <= 1'b0;
      r_lr_rec      <= 1'b0;
      r_cnt         <= '0;
      r_shift       <= '0;
      r_tx_word     <= '0;
      r_hold        <= '0;
      r_hold_full   <= 1'b0;
      r_ready       <= 1'b1;
      r_sd          <= 1'b0;
      r_frame_start <= 1'b0;
      r_underrun    <= 1'b0;
    end else begin
      r_bck_s1      <= bck_i;
      r_bck_s2      <= r_bck_s1;
      r_bck_d       <= r_bck_s2;
      r_lr_s1       <= lrck_i;
      r_lr_s2       <= r_lr_s1;
      if (w_fall) begin
        r_lr_rec <= r_lr_s2;
      end
      r_cnt         <= w_cnt_nxt;
      r_shift       <= w_shift_nxt;
      r_tx_word     <= w_tx_nxt;
      r_hold        <= w_hold_nxt;
      r_hold_full   <= w_full_nxt;
      r_ready       <= ~w_full_nxt;
      r_sd          <= w_sd_nxt;
      r_frame_start <= w_fs_nxt;
      r_underrun    <= w_ur_nxt;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
`timescale 1ns/1ps
// Bench for i2s_tx: drives BCK/LRCK as an I2S master, captures sd_out on
// BCK rising edges and compares each captured slot against a scoreboard.
module tb_i2s_tx;

  localparam int unsigned DATA_W = 24;
  localparam int unsigned SLOT_W = 32;
  localparam real BCK_HALF = 156.25;  // 3.2 MHz BCK

`ifdef I2S_TX_STEREO_DUP_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              bck_i = 1'b1;
  logic              lrck_i = 1'b0;
  logic [DATA_W-1:0] sample_data = '0;
  logic              sample_valid = 1'b0;
  logic              sample_ready;
  logic              sd_out;
  logic              frame_start;
  logic              underrun;

  i2s_tx #(.DATA_W(DATA_W), .SLOT_W(SLOT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .bck_i        (bck_i),
    .lrck_i       (lrck_i),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sd_out       (sd_out),
    .frame_start  (frame_start),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;  // 100 MHz

  // Running pulse-cycle counters, sampled away from the active edge
  int fs_cnt = 0;
  int ur_cnt = 0;
  always @(negedge clk) begin
    if (frame_start) fs_cnt++;
    if (underrun)    ur_cnt++;
  end

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0] bits;
    string       name;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic              give;
    logic [DATA_W-1:0] data;
    int                lbits;
    logic [DATA_W-1:0] exp_left;
    logic              exp_ur;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected capture: bit 0 is the one-bit delay, bits 1..DATA_W the word
  function automatic logic [63:0] pat(input logic [DATA_W-1:0] w, input int n);
    logic [63:0] p;
    p = '0;
    for (int k = 1; k <= int'(DATA_W) && k < n; k++) p[k] = w[DATA_W-k];
    return p;
  endfunction

  task automatic push_exp(input string name, input logic [63:0] bits);
    exp_t e;
    e.bits = bits;
    e.name = name;
    sb.push_back(e);
  endtask

  // Drive n BCK periods; LRCK is set to lr at the first falling edge
  task automatic run_slot(input logic lr, input int n, output logic [63:0] got);
    got = '0;
    for (int k = 0; k < n; k++) begin
      bck_i = 1'b0;
      if (k == 0) lrck_i = lr;
      #(BCK_HALF);
      got[k] = sd_out;
      bck_i = 1'b1;
      #(BCK_HALF);
    end
  endtask

  task automatic recv(input logic lr, input int n);
    logic [63:0] got;
    exp_t e;
    run_slot(lr, n, got);
    if (sb.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_empty: got %h expected none", got);
    end else begin
      e = sb.pop_front();
      chk(e.name, got, e.bits);
    end
  endtask

  task automatic offer(input logic [DATA_W-1:0] d);
    int t;
    t = 0;
    @(negedge clk);
    sample_data  = d;
    sample_valid = 1'b1;
    while (!sample_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("offer_ready_timeout", 64'(t < 200), 64'(1));
    @(posedge clk);
    #1 sample_valid = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs0, ur0;
    logic [DATA_W-1:0] rw;

    vecs[0] = '{1'b1, 24'h200000, 32, 24'h200000, 1'b0};
    vecs[1] = '{1'b0, 24'h000000, 32, 24'h000000, 1'b1};
    vecs[2] = '{1'b1, 24'hABCDEF, 32, 24'hABCDEF, 1'b0};
    vecs[3] = '{1'b1, 24'h800001, 40, 24'h800001, 1'b0};  // over-long slot

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_sd_out", 64'(sd_out), 64'(0));
    chk("rst_frame_start", 64'(frame_start), 64'(0));
    chk("rst_underrun", 64'(underrun), 64'(0));
    chk("rst_ready", 64'(sample_ready), 64'(1));
    reset = 1'b1;
    repeat (4) @(negedge clk);

    // First slot after reset is a right slot: nothing transmitted
    push_exp("init_right", pat('0, 32));
    recv(1'b1, 32);

    // Table-driven frames
    for (int i = 0; i < 4; i++) begin
      if (vecs[i].give) offer(vecs[i].data);
      fs0 = fs_cnt;
      ur0 = ur_cnt;
      push_exp($sformatf("v%0d_left", i), pat(vecs[i].exp_left, vecs[i].lbits));
      recv(1'b0, vecs[i].lbits);
      chk($sformatf("v%0d_frame_start", i), 64'(fs_cnt - fs0), 64'(1));
      chk($sformatf("v%0d_underrun", i), 64'(ur_cnt - ur0), 64'(vecs[i].exp_ur));
      chk($sformatf("v%0d_ready", i), 64'(sample_ready), 64'(1));
      rw = DUP ? vecs[i].exp_left : '0;
      push_exp($sformatf("v%0d_right", i), pat(rw, 32));
      recv(1'b1, 32);
    end

    // Back-to-back samples: second stalls until the left-slot start
    offer(24'h210000);
    @(negedge clk);
    sample_data  = 24'h220000;
    sample_valid = 1'b1;
    repeat (5) @(negedge clk);
    chk("bb_stall", 64'(sample_ready), 64'(0));
    push_exp("bb_left1", pat(24'h210000, 32));
    recv(1'b0, 32);
    chk("bb_second_taken", 64'(sample_ready), 64'(0));
    @(negedge clk);
    sample_valid = 1'b0;
    rw = DUP ? 24'h210000 : '0;
    push_exp("bb_right1", pat(rw, 32));
    recv(1'b1, 32);
    fs0 = fs_cnt;
    ur0 = ur_cnt;
    push_exp("bb_left2", pat(24'h220000, 32));
    recv(1'b0, 32);
    chk("bb_underrun2", 64'(ur_cnt - ur0), 64'(0));
    rw = DUP ? 24'h220000 : '0;
    push_exp("bb_right2", pat(rw, 32));
    recv(1'b1, 32);

    // Reset at bit 10 of a left slot
    offer(24'h5A5A5A);
    push_exp("rst_pre", pat(24'h5A5A5A, 10));
    recv(1'b0, 10);
    reset = 1'b0;
    #1;
    chk("rst_mid_sd_out", 64'(sd_out), 64'(0));
    chk("rst_mid_ready", 64'(sample_ready), 64'(1));
    chk("rst_mid_frame_start", 64'(frame_start), 64'(0));
    repeat (3) @(negedge clk);
    reset = 1'b1;
    push_exp("rst_rest", pat('0, 22));
    recv(1'b0, 22);
    offer(24'h5A5A5A);
    push_exp("rst_right", pat('0, 32));
    recv(1'b1, 32);
    fs0 = fs_cnt;
    push_exp("rst_left_after", pat(24'h5A5A5A, 32));
    recv(1'b0, 32);
    chk("rst_after_frame_start", 64'(fs_cnt - fs0), 64'(1));
    rw = DUP ? 24'h5A5A5A : '0;
    push_exp("rst_right_after", pat(rw, 32));
    recv(1'b1, 32);

    // LRCK toggled after 16 BCKs: truncated word, new slot keeps its delay bit
    offer(24'h3C3C3C);
    push_exp("trunc_left", pat(24'h3C3C3C, 16));
    recv(1'b0, 16);
    rw = DUP ? 24'h3C3C3C : '0;
    push_exp("trunc_right", pat(rw, 32));
    recv(1'b1, 32);

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
